fetch_buffer: RTL and testbench

//   Instruction queue between the fetch stage and the decode unit.
//   - Accepts fetched {instr, pc, pred_taken} tuples.
//   - Presents them in program order to decode via a valid/ready handshake.
//   - Decouples fetch stalls from decode/dispatch stalls.
//   - Discards all contents on a pipeline flush (mispredict / redirect).

---
 rtl/fetch_buffer.sv | 86 ++++++++
 tb/tb_fetch_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of
// {instr, pc, pred_taken} with valid/ready handshakes on both sides and a flush.
module fetch_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [31:0]              enq_instr_i,
  input  logic [31:0]              enq_pc_i,
  input  logic                     enq_pred_taken_i,
  output logic                     deq_valid_o,
  input  logic                     deq_ready_i,
  output logic [31:0]              deq_instr_o,
  output logic [31:0]              deq_pc_o,
  output logic                     deq_pred_taken_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;
  localparam logic [31:0] InstrNop = 32'h0000_0013;

  logic [AW:0] head_q, head_d;
  logic [AW:0] tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic [64:0] mem_q [DEPTH];

  logic empty, full, enq_fire, deq_fire;
  logic [64:0] head_entry;

  always_comb begin
    empty    = (head_q == tail_q);
    // Same index with differing wrap bits means tail has lapped head.
    full     = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    enq_fire = enq_valid_i & ~full;
    deq_fire = deq_ready_i & ~empty;
    head_d   = head_q;
    tail_d   = tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PtrOne;
      if (deq_fire) head_d = head_q + PtrOne;
    end
    count_d = tail_d - head_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (enq_fire && !flush_i) begin
      mem_q[tail_q[AW-1:0]] <= {enq_instr_i, enq_pc_i, enq_pred_taken_i};
    end
  end

  always_comb begin
    head_entry       = mem_q[head_q[AW-1:0]];
    enq_ready_o      = ~full;
    deq_valid_o      = ~empty;
    count_o          = count_q;
    deq_instr_o      = InstrNop;
    deq_pc_o         = '0;
    deq_pred_taken_o = 1'b0;
    if (!empty) begin
      deq_instr_o      = head_entry[64:33];
      deq_pc_o         = head_entry[32:1];
      deq_pred_taken_o = head_entry[0];
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fetch_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            enq_valid = 1'b0;
  logic            enq_ready;
  logic [31:0]     enq_instr = '0;
  logic [31:0]     enq_pc = '0;
  logic            enq_pred = 1'b0;
  logic            deq_valid;
  logic            deq_ready = 1'b0;
  logic [31:0]     deq_instr;
  logic [31:0]     deq_pc;
  logic            deq_pred;
  logic [CW-1:0]   count;

  int total = 0;
  int bad = 0;

  logic [64:0] model_q[$];
  logic        enq_fired;
  logic [31:0] seen_pc;
  logic [CW-1:0] seen_count;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .enq_valid_i      (enq_valid),
    .enq_ready_o      (enq_ready),
    .enq_instr_i      (enq_instr),
    .enq_pc_i         (enq_pc),
    .enq_pred_taken_i (enq_pred),
    .deq_valid_o      (deq_valid),
    .deq_ready_i      (deq_ready),
    .deq_instr_o      (deq_instr),
    .deq_pc_o         (deq_pc),
    .deq_pred_taken_o (deq_pred),
    .count_o          (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs with the model, then advance one clock and the model.
  task automatic step();
    logic [64:0] head;
    int sz;
    logic do_enq, do_deq;
    @(negedge clk);
    sz = model_q.size();
    head = (sz > 0) ? model_q[0] : {32'h0000_0013, 32'h0, 1'b0};
    check("enq_ready", enq_ready, sz < DEPTH);
    check("deq_valid", deq_valid, sz > 0);
    check("count", count, sz);
    check("deq_instr", deq_instr, head[64:33]);
    check("deq_pc", deq_pc, head[32:1]);
    check("deq_pred", deq_pred, head[0]);
    seen_pc = deq_pc;
    seen_count = count;
    do_enq = enq_valid && (sz < DEPTH) && !flush;
    do_deq = deq_ready && (sz > 0) && !flush;
    @(posedge clk);
    if (flush) model_q.delete();
    else begin
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back({enq_instr, enq_pc, enq_pred});
    end
    enq_fired = do_enq;
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [31:0] pc);
    enq_valid = v;
    enq_pc = pc;
    enq_instr = {pc[15:0], 16'h0013} ^ 32'h0000_1000;
    enq_pred = pc[2];
  endtask

  initial begin
    logic [31:0] prev_pc;
    logic [31:0] rpc;

    // Reset state
    #2;
    check("rst_count", count, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_deq_instr", deq_instr, 32'h0000_0013);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // 1: single enqueue visible next cycle
    enq_valid = 1'b1; enq_instr = 32'h0050_0093; enq_pc = 32'h4000_0000; enq_pred = 1'b0;
    step();
    enq_valid = 1'b0;
    #1;
    check("t1_deq_valid", deq_valid, 1);
    check("t1_instr", deq_instr, 32'h0050_0093);
    check("t1_pc", deq_pc, 32'h4000_0000);
    check("t1_count", count, 1);
    flush = 1'b1; step(); flush = 1'b0;

    // 2: fill, hold a 9th, release with one deq
    for (int k = 0; k < 8; k++) begin
      set_enq(1'b1, 32'h4000_0100 + 4 * k);
      step();
    end
    check("t2_count", count, 8);
    check("t2_full", enq_ready, 0);
    set_enq(1'b1, 32'h4000_0200);
    step();
    check("t2_held", enq_fired, 0);
    deq_ready = 1'b1;
    step();
    check("t2_ignored_full", enq_fired, 0);
    deq_ready = 1'b0;
    step();
    check("t2_accepted", enq_fired, 1);
    set_enq(1'b0, 32'h0);
    step();
    check("t2_count_after", count, 8);
    flush = 1'b1; step(); flush = 1'b0;

    // 3: steady stream through pointer wrap
    set_enq(1'b1, 32'h4000_0000);
    step();
    deq_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      set_enq(1'b1, 32'h4000_0000 + 4 * k);
      step();
      if (k > 1) check("t3_pc_inc", seen_pc, prev_pc + 32'd4);
      check("t3_count_const", seen_count, 1);
      prev_pc = seen_pc;
    end
    set_enq(1'b0, 32'h0);
    deq_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;

    // 4: flush with concurrent enq and deq
    for (int k = 0; k < 5; k++) begin
      set_enq(1'b1, 32'h4000_0300 + 4 * k);
      step();
    end
    set_enq(1'b1, 32'h4000_0400);
    deq_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0; deq_ready = 1'b0; set_enq(1'b0, 32'h0);
    check("t4_count", count, 0);
    check("t4_deq_valid", deq_valid, 0);
    check("t4_instr", deq_instr, 32'h0000_0013);

    // 5: deq on empty is ignored
    deq_ready = 1'b1;
    repeat (3) step();
    deq_ready = 1'b0;
    set_enq(1'b1, 32'h4000_0500);
    step();
    set_enq(1'b0, 32'h0);
    step();
    flush = 1'b1; step(); flush = 1'b0;

    // 6: asynchronous reset mid-cycle
    for (int k = 0; k < 3; k++) begin
      set_enq(1'b1, 32'h4000_0600 + 4 * k);
      step();
    end
    set_enq(1'b0, 32'h0);
    check("t6_pre_count", count, 3);
    #2 rst = 1'b1;
    #1;
    check("t6_count", count, 0);
    check("t6_deq_valid", deq_valid, 0);
    model_q.delete();
    rst = 1'b0;
    step();

    // Random traffic; enq data held stable until accepted.
    rpc = 32'h8000_0000;
    for (int k = 0; k < 400; k++) begin
      if (!enq_valid || enq_fired) begin
        enq_valid = ($urandom_range(0, 3) != 0);
        enq_pc = rpc;
        enq_instr = $urandom;
        enq_pred = $urandom_range(0, 1);
        rpc = rpc + 32'd4;
      end
      deq_ready = ($urandom_range(0, 2) != 0) && (k % 64 < 48);
      flush = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
